// File: rtl/rf_writeback_queue_if.sv
// Signal bundle between the execute/memory producers, the register file read
// ports and the writeback queue. Clock and reset stay outside the bundle.
interface rf_writeback_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 2
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          alu_valid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [AW-1:0] read_a;
   logic [AW-1:0] read_b;
   logic [DW-1:0] rf_a_data;
   logic [DW-1:0] rf_b_data;
   logic [DW-1:0] fwd_a_data;
   logic [DW-1:0] fwd_b_data;
   logic          write_enable;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic          stall;
   logic          overflow;
   logic [CW-1:0] count;

   modport slave (
      input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      input  read_a, read_b, rf_a_data, rf_b_data,
      output fwd_a_data, fwd_b_data, write_enable, write_addr, write_data,
      output stall, overflow, count
   );

   modport master (
      output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      output read_a, read_b, rf_a_data, rf_b_data,
      input  fwd_a_data, fwd_b_data, write_enable, write_addr, write_data,
      input  stall, overflow, count
   );
endinterface

// File: rtl/rf_writeback_queue.sv
// Program-ordered write queue in front of the register file write port: up to two
// pushes (load, then ALU) per cycle, one drain per cycle, with read forwarding.
module rf_writeback_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 2
) (
   input logic                  clk,
   input logic                  reset_n,
   rf_writeback_queue_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] head_q, tail_q, tail_d, alu_slot;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q;

   logic          pop, ld_acc, alu_acc, drop;
   int unsigned   free_slots;
   logic [DW-1:0] fwd_a, fwd_b;
   logic [PW-1:0] idx;

   // Pointer arithmetic modulo DEPTH; k never exceeds DEPTH-1, so one fold suffices.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   always_comb begin
      pop        = (count_q != '0);
      free_slots = DEPTH - 32'(count_q) + (pop ? 32'd1 : 32'd0);
      ld_acc     = bus.ld_valid && (free_slots >= 32'd1);
      // The load is older, so it claims a slot before the ALU result does.
      alu_acc    = bus.alu_valid && (free_slots >= (ld_acc ? 32'd2 : 32'd1));
      drop       = (bus.ld_valid && !ld_acc) || (bus.alu_valid && !alu_acc);
      alu_slot   = ld_acc ? wrap_add(tail_q, 1) : tail_q;
      tail_d     = wrap_add(tail_q, 32'(ld_acc) + 32'(alu_acc));
      count_d    = count_q + CW'(ld_acc) + CW'(alu_acc) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (ld_acc) begin
            addr_q[tail_q] <= bus.ld_addr;
            data_q[tail_q] <= bus.ld_data;
         end
         if (alu_acc) begin
            addr_q[alu_slot] <= bus.alu_addr;
            data_q[alu_slot] <= bus.alu_data;
         end
         if (pop) head_q <= wrap_add(head_q, 1);
         tail_q  <= tail_d;
         count_q <= count_d;
         if (drop) overflow_q <= 1'b1;
      end
   end

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_a = bus.rf_a_data;
      fwd_b = bus.rf_b_data;
      idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = wrap_add(head_q, i);
         if (i < 32'(count_q)) begin
            if (addr_q[idx] == bus.read_a) fwd_a = data_q[idx];
            if (addr_q[idx] == bus.read_b) fwd_b = data_q[idx];
         end
      end
   end

   assign bus.fwd_a_data   = fwd_a;
   assign bus.fwd_b_data   = fwd_b;
   assign bus.write_enable = pop;
   assign bus.write_addr   = addr_q[head_q];
   assign bus.write_data   = data_q[head_q];
   assign bus.stall        = (count_q >= CW'(DEPTH - 1));
   assign bus.overflow     = overflow_q;
   assign bus.count        = count_q;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios plus random traffic, checked
// against a queue-based model of pending writes and a model register file.
module tb_rf_writeback_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 2;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rf_init = 1'b0;
   logic [DW-1:0] rf_stub [4];

   ent_t        mq[$];
   logic [DW-1:0] rf_m [4];
   logic        ovf_m = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   rf_writeback_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

   rf_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Stand-in register file fed by the DUT write port.
   always @(posedge clk) begin
      if (!rf_init) begin
         for (int i = 0; i < 4; i++) rf_stub[i] <= '0;
      end else if (bus.write_enable) begin
         rf_stub[bus.write_addr] <= bus.write_data;
      end
   end
   assign bus.rf_a_data = rf_stub[bus.read_a];
   assign bus.rf_b_data = rf_stub[bus.read_b];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] ra);
      logic [DW-1:0] r;
      r = rf_m[ra];
      foreach (mq[i]) if (mq[i].a == ra) r = mq[i].d;
      return r;
   endfunction

   task automatic check_outputs();
      check_val("count", 32'(bus.count), 32'(mq.size()));
      check_val("write_enable", 32'(bus.write_enable), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         check_val("write_addr", 32'(bus.write_addr), 32'(mq[0].a));
         check_val("write_data", 32'(bus.write_data), 32'(mq[0].d));
      end
      check_val("stall", 32'(bus.stall), 32'(mq.size() >= DEPTH - 1));
      check_val("overflow", 32'(bus.overflow), 32'(ovf_m));
      check_val("fwd_a", 32'(bus.fwd_a_data), 32'(model_fwd(bus.read_a)));
      check_val("fwd_b", 32'(bus.fwd_b_data), 32'(model_fwd(bus.read_b)));
   endtask

   task automatic check_rf();
      for (int i = 0; i < 4; i++) check_val($sformatf("rf%0d", i), 32'(rf_stub[i]), 32'(rf_m[i]));
   endtask

   // One cycle: drive, check combinational outputs, clock, advance the model.
   task automatic step(input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      ent_t e;
      bus.ld_valid = lv;  bus.ld_addr = la;  bus.ld_data = ld;
      bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
      bus.read_a = ra;    bus.read_b = rb;
      #1;
      check_outputs();
      @(posedge clk);
      if (mq.size() != 0) begin
         e = mq.pop_front();
         rf_m[e.a] = e.d;
      end
      if (lv) begin
         if (mq.size() < DEPTH) mq.push_back('{a: la, d: ld});
         else ovf_m = 1'b1;
      end
      if (av) begin
         if (mq.size() < DEPTH) mq.push_back('{a: aa, d: ad});
         else ovf_m = 1'b1;
      end
      #1;
      check_rf();
   endtask

   task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);
   endtask

   // Assert reset between edges, confirm the immediate clear and that nothing is written.
   task automatic reset_mid();
      bus.ld_valid = 1'b0;
      bus.alu_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rst_count", 32'(bus.count), 32'd0);
      check_val("rst_we", 32'(bus.write_enable), 32'd0);
      check_val("rst_stall", 32'(bus.stall), 32'd0);
      check_val("rst_ovf", 32'(bus.overflow), 32'd0);
      mq.delete();
      ovf_m = 1'b0;
      @(posedge clk);
      #1;
      check_rf();
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      bit honor;
      bit lv, av;
      for (int i = 0; i < 4; i++) rf_m[i] = '0;
      bus.ld_valid = 1'b0;  bus.ld_addr = '0;  bus.ld_data = '0;
      bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
      bus.read_a = '0;      bus.read_b = '0;
      #1;
      check_val("reset_count", 32'(bus.count), 32'd0);
      check_val("reset_we", 32'(bus.write_enable), 32'd0);
      check_val("reset_waddr", 32'(bus.write_addr), 32'd0);
      check_val("reset_wdata", 32'(bus.write_data), 32'd0);
      check_val("reset_stall", 32'(bus.stall), 32'd0);
      check_val("reset_ovf", 32'(bus.overflow), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rf_init = 1'b1;
      #2;
      reset_n = 1'b1;

      // Single ALU result, forwarded then written.
      step(1'b0, '0, '0, 1'b1, 2'd2, 8'h5A, 2'd2, 2'd0);
      idle(2'd2, 2'd0);
      idle(2'd2, 2'd0);
      check_val("t1_r2", 32'(rf_stub[2]), 32'h5A);

      // Load and ALU to the same register in one cycle: ALU is younger.
      step(1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 8'h22, 2'd1, 2'd1);
      idle(2'd1, 2'd3);
      idle(2'd1, 2'd1);
      idle(2'd1, 2'd1);
      check_val("t2_r1", 32'(rf_stub[1]), 32'h22);

      // Dual pushes honoring stall: six writes, no overflow.
      for (int n = 0; n < 6;) begin
         if (mq.size() >= DEPTH - 1) begin
            idle(2'(n), 2'd0);
         end else begin
            step(1'b1, 2'(n), 8'(8'h30 + n), 1'b1, 2'(n + 1), 8'(8'h31 + n), 2'(n), 2'(n + 1));
            n += 2;
         end
      end
      for (int i = 0; i < 5; i++) idle(2'(i), 2'd3);
      check_val("t3_ovf", 32'(bus.overflow), 32'd0);

      // Ignore stall until the queue is full; ALU result dropped first.
      for (int i = 0; i < 4; i++)
         step(1'b1, 2'(i), 8'(8'h40 + 2 * i), 1'b1, 2'(i + 2), 8'(8'h41 + 2 * i), 2'(i), 2'd2);
      check_val("t4_count", 32'(bus.count), 32'd4);
      idle(2'd0, 2'd1);
      check_val("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

      // Count is 3 here; reset mid-cycle.
      check_val("t5_pre_count", 32'(bus.count), 32'd3);
      reset_mid();

      // Pointer wrap over ten single pushes.
      for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 2'(i), 8'(i), 2'(i), 2'(i + 3));
      for (int i = 0; i < 3; i++) idle(2'd0, 2'd3);
      check_val("t6_count", 32'(bus.count), 32'd0);
      check_val("t6_r0", 32'(rf_stub[0]), 32'h08);
      check_val("t6_r1", 32'(rf_stub[1]), 32'h09);
      check_val("t6_r2", 32'(rf_stub[2]), 32'h06);
      check_val("t6_r3", 32'(rf_stub[3]), 32'h07);

      // Random traffic, alternating between honoring and ignoring stall.
      honor = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 24) == 0) honor = ~honor;
         if ($urandom_range(0, 59) == 0) begin
            reset_mid();
         end else begin
            lv = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            if (honor && mq.size() >= DEPTH - 1) begin
               lv = 1'b0;
               av = 1'b0;
            end
            step(lv, 2'($urandom), 8'($urandom), av, 2'($urandom), 8'($urandom),
                 2'($urandom), 2'($urandom));
         end
      end
      for (int i = 0; i < 6; i++) idle(2'(i), 2'(i + 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
